// File: rtl/wired_jump_pkg.sv
// Shared types and encodings for the wired_jump resolver and its round-robin scheduler.
package wired_jump_pkg;

  localparam int JS_NREQ = 2;
  localparam int ROB_W   = 6;
  localparam int SRC_W   = (JS_NREQ > 1) ? $clog2(JS_NREQ) : 1;

  typedef enum logic [1:0] {
    TARGET_NONE = 2'd0,
    TARGET_CALL = 2'd1,
    TARGET_ABS  = 2'd2,
    TARGET_IMM  = 2'd3
  } target_type_e;

  // cmp_type bits: [0] equal, [1] signed less-than, [2] unsigned less-than, [3] invert.
  localparam logic [3:0] CMP_NEVER  = 4'b0000;
  localparam logic [3:0] CMP_EQ     = 4'b0001;
  localparam logic [3:0] CMP_LT     = 4'b0010;
  localparam logic [3:0] CMP_LTU    = 4'b0100;
  localparam logic [3:0] CMP_ALWAYS = 4'b1000;
  localparam logic [3:0] CMP_NE     = 4'b1001;
  localparam logic [3:0] CMP_GE     = 4'b1010;
  localparam logic [3:0] CMP_GEU    = 4'b1100;

  typedef struct packed {
    logic [31:0]      r0;
    logic [31:0]      r1;
    logic [31:0]      pc;
    logic [27:0]      addr_imm;
    target_type_e     target_type;
    logic [3:0]       cmp_type;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [ROB_W-1:0] rob_id;
  } jump_req_t;

  typedef struct packed {
    logic [ROB_W-1:0] rob_id;
    logic             taken;
    logic [31:0]      target;
    logic [31:0]      next_pc;
    logic             mispred;
    logic [SRC_W-1:0] src;
  } jump_res_t;

  function automatic logic [31:0] sext_imm(input logic [27:0] imm);
    return {{4{imm[27]}}, imm};
  endfunction

  function automatic logic cmp_eval(input logic [3:0] cmp, input logic [31:0] a,
                                    input logic [31:0] b);
    logic hit;
    hit = (cmp[0] & (a == b)) |
          (cmp[1] & ($signed(a) < $signed(b))) |
          (cmp[2] & (a < b));
    return hit ^ cmp[3];
  endfunction

endpackage

// File: rtl/wired_jump.sv
// Combinational branch resolver: condition, target, next pc and mispredict against the prediction.
module wired_jump
  import wired_jump_pkg::*;
(
  input  jump_req_t        req_i,
  input  logic [SRC_W-1:0] src_i,
  output jump_res_t        res_o
);

  logic [31:0] base_s;
  logic [31:0] target_s;
  logic        taken_s;

  // Resolve the selected request into a result record.
  always_comb begin
    base_s = req_i.pc;
    case (req_i.target_type)
      TARGET_ABS:  base_s = req_i.r1;
      TARGET_CALL: base_s = req_i.pc;
      TARGET_IMM:  base_s = req_i.pc;
      default:     base_s = req_i.pc;
    endcase
    target_s = sext_imm(req_i.addr_imm) + base_s;
    if (req_i.target_type == TARGET_NONE) begin
      taken_s = 1'b0;
    end else begin
      taken_s = cmp_eval(req_i.cmp_type, req_i.r0, req_i.r1);
    end
    res_o.rob_id  = req_i.rob_id;
    res_o.taken   = taken_s;
    res_o.target  = target_s;
    res_o.next_pc = taken_s ? target_s : (req_i.pc + 32'd4);
    res_o.mispred = (taken_s != req_i.pred_taken) |
                    (taken_s & (target_s != req_i.pred_target));
    res_o.src     = src_i;
  end

endmodule

// File: rtl/wired_jump_sched.sv
// Round-robin scheduler sharing one wired_jump resolver between NREQ issue pipes,
// with a registered result stage and handshake-counted branch/mispredict statistics.
module wired_jump_sched
  import wired_jump_pkg::*;
#(
  parameter int NREQ = JS_NREQ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  jump_req_t [NREQ-1:0]   req_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output jump_res_t              res_o,
  output logic [31:0]            branch_cnt_o,
  output logic [31:0]            mispred_cnt_o
);

  localparam logic [SRC_W:0] NREQ_W = (SRC_W + 1)'(NREQ);

  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic             res_valid_q, res_valid_d;
  jump_res_t        res_q, res_d;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;

  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [NREQ-1:0]   grant_s;
  logic [SRC_W-1:0]  enc_s;
  logic [SRC_W-1:0]  gidx_s;
  logic [SRC_W:0]    sum_s;
  logic [SRC_W:0]    wrap_s;
  logic [SRC_W:0]    inc_s;
  logic              any_s;
  logic              accept_s;
  logic              hs_s;
  jump_req_t         sel_req_s;
  jump_res_t         resolved_s;

  // Arbiter: rotate by the pointer, pick the lowest valid, rotate the index back.
  always_comb begin
    dbl_s = {req_valid_i, req_valid_i};
    rot_s = dbl_s[ptr_q +: NREQ];
    any_s = |req_valid_i;
    enc_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        enc_s = SRC_W'(i);
      end else begin
        enc_s = enc_s;
      end
    end
    sum_s  = {1'b0, enc_s} + {1'b0, ptr_q};
    wrap_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
    gidx_s = wrap_s[SRC_W-1:0];
    if (any_s) begin
      grant_s = NREQ'(1) << gidx_s;
    end else begin
      grant_s = '0;
    end
    sel_req_s = req_i[gidx_s];
  end

  wired_jump u_wired_jump (
    .req_i (sel_req_s),
    .src_i (gidx_s),
    .res_o (resolved_s)
  );

  // Accept/handshake qualification and next-state for the result stage, pointer and counters.
  always_comb begin
    accept_s    = any_s & (~res_valid_q | res_ready_i) & ~flush_i & ~rst;
    req_ready_o = grant_s & {NREQ{accept_s}};
    hs_s        = res_valid_q & res_ready_i & ~flush_i;

    res_valid_d   = res_valid_q;
    res_d         = res_q;
    ptr_d         = ptr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    inc_s         = {1'b0, gidx_s} + {{SRC_W{1'b0}}, 1'b1};

    if (flush_i) begin
      res_valid_d = 1'b0;
    end else if (accept_s) begin
      res_valid_d = 1'b1;
      res_d       = resolved_s;
      ptr_d       = (inc_s >= NREQ_W) ? '0 : inc_s[SRC_W-1:0];
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    if (hs_s) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (res_q.mispred) begin
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      end else begin
        mispred_cnt_d = mispred_cnt_q;
      end
    end else begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      res_valid_q   <= 1'b0;
      res_q         <= '0;
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      ptr_q         <= ptr_d;
      res_valid_q   <= res_valid_d;
      res_q         <= res_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign res_valid_o   = res_valid_q;
  assign res_o         = res_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_wired_jump_sched.sv
// Directed self-checking bench for wired_jump_sched with hand-computed expectations.
module tb_wired_jump_sched;
  import wired_jump_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  jump_req_t [1:0] req;
  logic            res_valid;
  logic            res_ready;
  jump_res_t       res;
  logic [31:0]     bcnt;
  logic [31:0]     mcnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wired_jump_sched #(.NREQ(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_i         (req),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_o         (res),
    .branch_cnt_o  (bcnt),
    .mispred_cnt_o (mcnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic jump_req_t mk(input logic [31:0] r0, input logic [31:0] r1,
                                   input logic [31:0] pc, input logic [27:0] imm,
                                   input target_type_e tt, input logic [3:0] cmp,
                                   input logic pt, input logic [31:0] ptg,
                                   input logic [5:0] rob);
    jump_req_t r;
    r.r0 = r0; r.r1 = r1; r.pc = pc; r.addr_imm = imm; r.target_type = tt;
    r.cmp_type = cmp; r.pred_taken = pt; r.pred_target = ptg; r.rob_id = rob;
    return r;
  endfunction

  jump_req_t  p0, p1n, p1a, p0n;
  logic [1:0] exp_g;

  initial begin
    p0  = mk(32'd5, 32'd5, 32'h1000, 28'h40, TARGET_IMM, CMP_EQ, 1'b1, 32'h1040, 6'd3);
    p1n = mk(32'd1, 32'd2, 32'h3000, 28'h100, TARGET_IMM, CMP_EQ, 1'b0, 32'h0, 6'd9);
    p1a = mk(32'd0, 32'h8000_0000, 32'h4000, 28'hFFF_FFFC, TARGET_ABS, CMP_ALWAYS,
             1'b1, 32'h0, 6'd21);
    p0n = mk(32'd7, 32'd7, 32'h2000, 28'h80, TARGET_NONE, CMP_EQ, 1'b1, 32'h2080, 6'd5);

    // 1: reset, then a single correctly-predicted IMM branch from pipe0
    rst = 1'b1; flush = 1'b0; res_ready = 1'b0;
    req[0] = p0; req[1] = p1n; req_valid = 2'b01;
    repeat (3) tick();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_bcnt", 64'(bcnt), 64'd0);
    check("rst_mcnt", 64'(mcnt), 64'd0);
    rst = 1'b0; res_ready = 1'b1;
    #1;
    check("t1_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    check("t1_valid", 64'(res_valid), 64'd1);
    check("t1_taken", 64'(res.taken), 64'd1);
    check("t1_target", 64'(res.target), 64'h1040);
    check("t1_next_pc", 64'(res.next_pc), 64'h1040);
    check("t1_mispred", 64'(res.mispred), 64'd0);
    check("t1_src", 64'(res.src), 64'd0);
    check("t1_rob", 64'(res.rob_id), 64'd3);
    tick();
    check("t1_drain", 64'(res_valid), 64'd0);
    check("t1_bcnt", 64'(bcnt), 64'd1);
    check("t1_mcnt", 64'(mcnt), 64'd0);

    // 2: both pipes valid, full throughput; pointer is 1 after pipe0's grant
    req_valid = 2'b11;
    exp_g = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_grant", 64'(req_ready), 64'(exp_g));
      tick();
      check("t2_valid", 64'(res_valid), 64'd1);
      check("t2_src", 64'(res.src), (exp_g == 2'b01) ? 64'd0 : 64'd1);
      check("t2_next_pc", 64'(res.next_pc), (exp_g == 2'b01) ? 64'h1040 : 64'h3004);
      exp_g = ~exp_g;
    end
    req_valid = 2'b00;
    tick();
    check("t2_bcnt", 64'(bcnt), 64'd5);
    check("t2_mcnt", 64'(mcnt), 64'd0);
    check("t2_drain", 64'(res_valid), 64'd0);

    // 3: ABS target wraps modulo 2^32 and mispredicts; counted only on handshake
    req[1] = p1a; req_valid = 2'b10; res_ready = 1'b0;
    #1;
    check("t3_ready", 64'(req_ready), 64'd2);
    tick();
    check("t3_valid", 64'(res_valid), 64'd1);
    check("t3_taken", 64'(res.taken), 64'd1);
    check("t3_target", 64'(res.target), 64'h7FFF_FFFC);
    check("t3_mispred", 64'(res.mispred), 64'd1);
    check("t3_src", 64'(res.src), 64'd1);
    check("t3_mcnt_capture", 64'(mcnt), 64'd0);

    // 4: back-pressure holds the result and freezes arbitration
    req[1] = p1n; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t4_ready_held", 64'(req_ready), 64'd0);
      tick();
      check("t4_valid", 64'(res_valid), 64'd1);
      check("t4_target", 64'(res.target), 64'h7FFF_FFFC);
      check("t4_rob", 64'(res.rob_id), 64'd21);
    end
    check("t4_bcnt_held", 64'(bcnt), 64'd5);
    res_ready = 1'b1;
    #1;
    check("t4_ready_reload", 64'(req_ready), 64'd1);
    tick();
    check("t4_bcnt", 64'(bcnt), 64'd6);
    check("t4_mcnt", 64'(mcnt), 64'd1);
    check("t4_valid", 64'(res_valid), 64'd1);
    check("t4_src", 64'(res.src), 64'd0);
    check("t4_new_rob", 64'(res.rob_id), 64'd3);

    // 5: flush kills the pending result and blocks accepts
    res_ready = 1'b0; flush = 1'b1;
    #1;
    check("t5_ready_flush", 64'(req_ready), 64'd0);
    tick();
    check("t5_valid", 64'(res_valid), 64'd0);
    check("t5_bcnt", 64'(bcnt), 64'd6);
    check("t5_mcnt", 64'(mcnt), 64'd1);
    flush = 1'b0; res_ready = 1'b1;
    #1;
    check("t5_ptr_kept", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    check("t5_src", 64'(res.src), 64'd1);
    check("t5_bcnt_after", 64'(bcnt), 64'd6);
    tick();
    check("t5_bcnt_hs", 64'(bcnt), 64'd7);
    check("t5_mcnt_hs", 64'(mcnt), 64'd1);

    // 6: TARGET_NONE never taken; counters wrap from all-ones
    req[0] = p0n; req_valid = 2'b01;
    #1;
    check("t6_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    check("t6_taken", 64'(res.taken), 64'd0);
    check("t6_next_pc", 64'(res.next_pc), 64'h2004);
    check("t6_mispred", 64'(res.mispred), 64'd1);
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    #1;
    check("t6_bcnt_preset", 64'(bcnt), 64'hFFFF_FFFF);
    check("t6_mcnt_preset", 64'(mcnt), 64'hFFFF_FFFF);
    tick();
    check("t6_bcnt_wrap", 64'(bcnt), 64'd0);
    check("t6_mcnt_wrap", 64'(mcnt), 64'd0);
    check("t6_drain", 64'(res_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
